// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared widths, requester indices and FSM encoding for the
//            table-memory port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 11;
    localparam int DEF_DATA_W  = 16;
    localparam int OWNER_W     = 3;

    // Fixed requester slots of the learning engines.
    localparam int REQ_REWARD = 0;
    localparam int REQ_QUPD   = 1;
    localparam int REQ_NBR    = 2;
    localparam int REQ_HOST   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HANDOFF = 2'd2
    } arb_state_t;

    // Index width that can address every requester (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Engine-side request bus plus memory-macro bus of the arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        grant;
    logic [OWNER_W-1:0]        owner;
    logic                      busy;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    // Engines and the memory macro together form the master side.
    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  grant, owner, busy, rvalid, rdata, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output grant, owner, busy, rvalid, rdata, mem_addr, mem_we, mem_wdata
    );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin priority encoder; scans upward from
//            i_ptr+1 (mod NUM_REQ) and reports the first set request.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = 2
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0]   i_ptr,
    output logic      [NUM_REQ-1:0] o_onehot,
    output logic      [IDX_W-1:0]   o_idx,
    output logic                    o_found
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_found  = 1'b0;
        w_cand   = '0;
        // Offset 1..NUM_REQ so the last winner is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_found && i_req[w_cand]) begin
                o_found          = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin, burst-locked arbiter sharing one synchronous-read
//            table memory port among the learning engines.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_port_arbiter_if.slave bus
);

    localparam int               c_IDX_W   = idx_width(NUM_REQ);
    localparam logic [c_IDX_W-1:0] c_RR_INIT = c_IDX_W'(NUM_REQ - 1);

    arb_state_t          r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_rvalid;
    logic [c_IDX_W-1:0]  r_owner;
    logic [c_IDX_W-1:0]  r_rr;

    logic [NUM_REQ-1:0]  w_win;
    logic [c_IDX_W-1:0]  w_win_idx;
    logic                w_found;
    logic                w_busy;
    logic                w_owner_req;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .i_req    (bus.req),
        .i_ptr    (r_rr),
        .o_onehot (w_win),
        .o_idx    (w_win_idx),
        .o_found  (w_found)
    );

    // The grant is one-hot (or zero), so OR-ing the selected lanes is a mux
    // that naturally yields zero while the port is idle.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_mem_addr  = w_mem_addr  | bus.req_addr[i*ADDR_W +: ADDR_W];
                w_mem_wdata = w_mem_wdata | bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_busy      = |r_grant;
    assign w_mem_we    = |(r_grant & bus.req_we);
    assign w_owner_req = |(r_grant & bus.req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr     <= c_RR_INIT;
            r_rvalid <= '0;
        end else begin
            // A granted non-write cycle returns data on the next cycle,
            // tagged to whoever owned the port when the address was issued.
            r_rvalid <= w_mem_we ? '0 : r_grant;

            case (r_state)
                IDLE, HANDOFF: begin
                    if (w_found) begin
                        r_grant <= w_win;
                        r_owner <= w_win_idx;
                        r_rr    <= w_win_idx;
                        r_state <= GRANT;
                    end else begin
                        r_grant <= '0;
                        r_owner <= '0;
                        r_state <= IDLE;
                    end
                end
                GRANT: begin
                    // Only the owner's request matters until it lets go.
                    if (!w_owner_req) begin
                        r_grant <= '0;
                        r_owner <= '0;
                        r_state <= HANDOFF;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_owner <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.owner     = OWNER_W'(r_owner);
    assign bus.busy      = w_busy;
    assign bus.rvalid    = r_rvalid;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_wdata = w_mem_wdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed scenarios plus random engine traffic against a
//            cycle-level reference model of the arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [NUM_REQ-1:0] tb_req;
    logic [NUM_REQ-1:0] tb_we;
    logic [ADDR_W-1:0]  tb_addr  [NUM_REQ];
    logic [DATA_W-1:0]  tb_wdata [NUM_REQ];
    logic [DATA_W-1:0]  tb_rdata;

    // Reference model: current owner (-1 idle), last winner, pending read tag.
    int m_owner;
    int m_rr;
    int m_tag;

    int held  [NUM_REQ];
    int burst [NUM_REQ];

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] r, input int from);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(from + k) % NUM_REQ]) return (from + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_rr    = NUM_REQ - 1;
        m_tag   = -1;
    endtask

    task automatic apply_inputs();
        bus.req       = tb_req;
        bus.req_we    = tb_we;
        bus.mem_rdata = tb_rdata;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_addr[i*ADDR_W +: ADDR_W]  = tb_addr[i];
            bus.req_wdata[i*DATA_W +: DATA_W] = tb_wdata[i];
        end
    endtask

    // Owner releases only when its own req is low; otherwise an idle or
    // dead cycle hands the port to the next requester after the last winner.
    task automatic advance_model();
        int nxt_tag;
        int w;
        nxt_tag = (m_owner >= 0 && !tb_we[m_owner]) ? m_owner : -1;
        if (m_owner >= 0) begin
            if (!tb_req[m_owner]) m_owner = -1;
        end else begin
            w = pick(tb_req, m_rr);
            if (w >= 0) begin
                m_owner = w;
                m_rr    = w;
            end
        end
        m_tag = nxt_tag;
    endtask

    task automatic check_outputs();
        logic [NUM_REQ-1:0] eg;
        logic [NUM_REQ-1:0] erv;
        logic [ADDR_W-1:0]  ea;
        logic [DATA_W-1:0]  ed;
        logic               ewe;
        int                 eo;
        eg = '0; erv = '0; ea = '0; ed = '0; ewe = 1'b0; eo = 0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            eo  = m_owner;
            ea  = tb_addr[m_owner];
            ed  = tb_wdata[m_owner];
            ewe = tb_we[m_owner];
        end
        if (m_tag >= 0) erv[m_tag] = 1'b1;
        check_value("grant",     32'(bus.grant),     32'(eg));
        check_value("owner",     32'(bus.owner),     32'(eo));
        check_value("busy",      32'(bus.busy),      32'(m_owner >= 0));
        check_value("rvalid",    32'(bus.rvalid),    32'(erv));
        check_value("mem_addr",  32'(bus.mem_addr),  32'(ea));
        check_value("mem_we",    32'(bus.mem_we),    32'(ewe));
        check_value("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
        if (erv != '0) check_value("rdata", 32'(bus.rdata), 32'(tb_rdata));
    endtask

    task automatic step();
        apply_inputs();
        advance_model();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clear_inputs();
        tb_req   = '0;
        tb_we    = '0;
        tb_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tb_addr[i]  = '0;
            tb_wdata[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        apply_inputs();
        model_reset();
        #7;
        rst = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    localparam logic [3:0] T2_REQ [12] = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1100,
                                           4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    localparam logic [3:0] T2_GNT [12] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                           4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000};

    initial begin
        do_reset();

        // Single read from requester 0.
        tb_req = 4'b0001; tb_addr[0] = 11'h010; tb_we = 4'b0000; tb_rdata = 16'hBEEF;
        step();
        check_value("t1_grant", 32'(bus.grant), 32'h1);
        check_value("t1_addr",  32'(bus.mem_addr), 32'h010);
        step();
        check_value("t1_rvalid", 32'(bus.rvalid), 32'h1);
        check_value("t1_rdata",  32'(bus.rdata), 32'hBEEF);
        tb_req = '0;
        step();
        step();

        // Four simultaneous requests, two-cycle bursts.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            tb_req = T2_REQ[c];
            step();
            check_value("t2_grant", 32'(bus.grant), 32'(T2_GNT[c]));
        end

        // Write burst by requester 1 with requester 2 arriving mid-burst.
        do_reset();
        tb_req = 4'b0010; tb_we = 4'b0110; tb_addr[1] = 11'h7FF; tb_wdata[1] = 16'hA5A5;
        tb_addr[2] = 11'h123; tb_wdata[2] = 16'h0F0F;
        step();
        check_value("t3_we",    32'(bus.mem_we), 32'h1);
        check_value("t3_addr",  32'(bus.mem_addr), 32'h7FF);
        check_value("t3_wdata", 32'(bus.mem_wdata), 32'hA5A5);
        tb_req = 4'b0110;
        step();
        check_value("t3_hold", 32'(bus.grant), 32'h2);
        tb_req = 4'b0100;
        step();
        check_value("t3_dead_grant", 32'(bus.grant), 32'h0);
        check_value("t3_dead_we",    32'(bus.mem_we), 32'h0);
        step();
        check_value("t3_next", 32'(bus.grant), 32'h4);

        // Read on the owner's final cycle returns during the dead cycle.
        do_reset();
        tb_req = 4'b0101; tb_we = 4'b0000;
        step();
        tb_we = 4'b0001;
        step();
        tb_req = 4'b0100; tb_we = 4'b0000; tb_rdata = 16'h1234;
        step();
        check_value("t4_dead_grant",  32'(bus.grant), 32'h0);
        check_value("t4_dead_rvalid", 32'(bus.rvalid), 32'h1);
        step();
        check_value("t4_new_grant", 32'(bus.grant), 32'h4);
        step();
        check_value("t4_new_rvalid", 32'(bus.rvalid), 32'h4);

        // Asynchronous reset mid-burst with a read return pending.
        do_reset();
        tb_req = 4'b0001; tb_we = 4'b0000;
        step();
        step();
        check_value("t5_pending", 32'(bus.rvalid), 32'h1);
        tb_we = 4'b0001;
        apply_inputs();
        #1;
        check_value("t5_pre_we", 32'(bus.mem_we), 32'h1);
        #1 rst = 1'b1;
        #1;
        check_value("t5_rst_grant",  32'(bus.grant), 32'h0);
        check_value("t5_rst_rvalid", 32'(bus.rvalid), 32'h0);
        check_value("t5_rst_we",     32'(bus.mem_we), 32'h0);
        model_reset();
        tb_req = 4'b0110; tb_we = '0;
        apply_inputs();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_outputs();
        step();
        check_value("t5_first", 32'(bus.grant), 32'h2);

        // Re-raising requester 0 queues behind waiting requester 3.
        do_reset();
        tb_req = 4'b0001;
        step();
        tb_req = 4'b1001;
        step();
        tb_req = 4'b1000;
        step();
        tb_req = 4'b1001;
        step();
        check_value("t6_fair", 32'(bus.grant), 32'h8);
        tb_req = 4'b0001;
        step();
        step();
        check_value("t6_then0", 32'(bus.grant), 32'h1);

        // Random engine traffic.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            held[i]  = 0;
            burst[i] = 1;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (tb_req[i]) begin
                    if (m_owner == i) begin
                        held[i]++;
                        if (held[i] >= burst[i]) tb_req[i] = 1'b0;
                    end else if ($urandom_range(0, 31) == 0) begin
                        tb_req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    tb_req[i] = 1'b1;
                    held[i]   = 0;
                    burst[i]  = int'($urandom_range(1, 5));
                end
                tb_we[i]    = 1'($urandom_range(0, 1));
                tb_addr[i]  = ADDR_W'($urandom);
                tb_wdata[i] = DATA_W'($urandom);
            end
            tb_rdata = DATA_W'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
